ours_ppln_rr_arb: RTL and testbench

//   Round-robin arbiter that shares one registered valid/ready pipeline stage among NUM_REQ upstream requesters.

---
 rtl/ours_ppln_rr_arb_pkg.sv | 15 +
 rtl/ours_ppln_rr_arb_if.sv | 40 ++++
 rtl/ours_rr_pick.sv | 33 +++
 rtl/ours_ppln_rr_arb.sv | 148 ++++++++++++++
 tb/tb_ours_ppln_rr_arb.sv | 137 +++++++++++++
 5 files changed

// File: rtl/ours_ppln_rr_arb_pkg.sv
// Shared types and helpers for the pipelined round-robin arbiter.
// The lock FSM encoding is only used when OURS_PPLN_ARB_BURST_EN is defined.
package ours_ppln_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Modulo-n increment used to advance the rotating priority pointer
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/ours_ppln_rr_arb_if.sv
// Requester-side and downstream handshake bundle of the round-robin arbiter.
// req_last is present only when OURS_PPLN_ARB_BURST_EN is defined.
interface ours_ppln_rr_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
`ifdef OURS_PPLN_ARB_BURST_EN
  logic [NUM_REQ-1:0]       req_last;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]         out_src;

`ifdef OURS_PPLN_ARB_BURST_EN
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
`else
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
`endif

endinterface

// File: rtl/ours_rr_pick.sv
// Combinational rotating-priority picker: first set request scanning from i_base upward, wrapping.
module ours_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_base,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int unsigned w_j;

  // Scan from farthest to nearest so the nearest asserted request wins last
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_j = (32'(i_base) + 32'(k)) % NUM_REQ;
      if (i_req[IDX_W'(w_j)]) begin
        o_idx = IDX_W'(w_j);
        o_any = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      o_gnt[i] = o_any && (o_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ours_ppln_rr_arb.sv
// Round-robin arbiter feeding one registered valid/ready stage shared by NUM_REQ requesters.
// Define OURS_PPLN_ARB_BURST_EN to hold the grant on a requester until its req_last beat.
module ours_ppln_rr_arb
  import ours_ppln_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input logic               clk,
  input logic               rstn,
  ours_ppln_rr_arb_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [IDX_W-1:0]   r_out_src;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_req_eff;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_stage_free;
  logic               w_accept;
  logic [WIDTH-1:0]   w_data;

`ifdef OURS_PPLN_ARB_BURST_EN
  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_LOCK = 1'(LOCK);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [IDX_W-1:0]   r_lock_idx;
  logic [IDX_W-1:0]   w_lock_nxt;
  logic               w_last;

  // While locked only the burst owner is visible to the picker
  always_comb begin
    w_req_eff = bus.req_valid;
    if (r_state == ST_LOCK) begin
      w_req_eff             = '0;
      w_req_eff[r_lock_idx] = bus.req_valid[r_lock_idx];
    end
  end
`else
  assign w_req_eff = bus.req_valid;
`endif

  ours_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req  (w_req_eff),
    .i_base (r_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_stage_free  = ~r_out_valid | bus.out_ready;
  assign w_accept      = rstn & w_stage_free & w_any;
  assign bus.req_ready = w_accept ? w_gnt : '0;

  always_comb begin
    w_data = '0;
`ifdef OURS_PPLN_ARB_BURST_EN
    w_last = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_gnt[i]) begin
        w_data = bus.req_data[i*int'(WIDTH) +: WIDTH];
      end
`ifdef OURS_PPLN_ARB_BURST_EN
      w_last = w_last | (w_gnt[i] & bus.req_last[i]);
`endif
    end
  end

  // Pointer advance and optional burst lock
  always_comb begin
    w_ptr_nxt = r_ptr;
`ifdef OURS_PPLN_ARB_BURST_EN
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_idx;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_last) begin
            w_ptr_nxt = IDX_W'(rr_next(32'(w_idx), NUM_REQ));
          end else begin
            w_state_nxt = ST_LOCK;
            w_lock_nxt  = w_idx;
          end
        end
        ST_LOCK: begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = IDX_W'(rr_next(32'(r_lock_idx), NUM_REQ));
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
`else
    if (w_accept) begin
      w_ptr_nxt = IDX_W'(rr_next(32'(w_idx), NUM_REQ));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_ptr       <= '0;
`ifdef OURS_PPLN_ARB_BURST_EN
      r_state     <= ST_IDLE;
      r_lock_idx  <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_src   <= w_idx;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_ptr <= w_ptr_nxt;
`ifdef OURS_PPLN_ARB_BURST_EN
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_nxt;
`endif
    end
  end

  // Payload register carries no reset; w_accept is already low during reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_out_data <= w_data;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_ours_ppln_rr_arb.sv
// Directed bench for ours_ppln_rr_arb (NUM_REQ=4, WIDTH=8); burst cases run with OURS_PPLN_ARB_BURST_EN.
module tb_ours_ppln_rr_arb;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_pass;

  ours_ppln_rr_arb_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

  ours_ppln_rr_arb #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Drive at posedge+1, check req_ready at negedge, check registered outputs after next posedge
  task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] exp_rdy,
                      input logic exp_ov, input logic [1:0] exp_src, input string nm);
    bus.req_valid = v;
    bus.out_ready = rdy;
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(exp_ov));
    chk({nm, " out_src"}, 32'(bus.out_src), 32'(exp_src));
    if (exp_ov) chk({nm, " out_data"}, 32'(bus.out_data), 32'(8'hA0 + 8'(exp_src)));
  endtask

`ifdef OURS_PPLN_ARB_BURST_EN
  task automatic step_b(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                        input logic [3:0] exp_rdy, input logic exp_ov, input logic [1:0] exp_src,
                        input string nm);
    bus.req_last = l;
    step(v, rdy, exp_rdy, exp_ov, exp_src, nm);
  endtask
`endif

  task automatic reset_cycle(input logic [3:0] v, input string nm);
    rstn          = 1'b0;
    bus.req_valid = v;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, " out_src"}, 32'(bus.out_src), 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    // ptr tracked in comments after each accept
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 1
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1}; // ptr 2
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2}; // ptr 3
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3}; // ptr 0
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 1
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1}; // ptr 2
    vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[11] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2}; // ptr 3
    vecs[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1}; // ptr 2
    vecs[13] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3}; // ptr wraps to 0
    vecs[14] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1}; // ptr 2
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1}; // drain, ptr holds
    vecs[16] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2}; // ptr 3
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[18] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[19] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 1

    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
`ifdef OURS_PPLN_ARB_BURST_EN
    bus.req_last  = 4'b1111;
`endif
    rstn = 1'b0;

    // Two reset cycles with every requester asking
    reset_cycle(4'b1111, "rst0");
    reset_cycle(4'b1111, "rst1");

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].valid, vecs[i].ready, vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_src,
           $sformatf("vec%0d", i));
    end

    // Reset with ptr at 1 must restart scanning from requester 0
    reset_cycle(4'b1111, "rst_mid");
    step(4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, "post_rst"); // ptr 1

`ifdef OURS_PPLN_ARB_BURST_EN
    step_b(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, "pre_burst"); // ptr 2
    step_b(4'b1111, 4'b1011, 1'b1, 4'b0100, 1'b1, 2'd2, "burst_b1");
    step_b(4'b1111, 4'b1011, 1'b1, 4'b0100, 1'b1, 2'd2, "burst_b2");
    step_b(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, "burst_b3"); // ptr 3
    step_b(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, "after_b0");
    step_b(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, "after_b1");
    step_b(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, "after_b2"); // ptr 2
    step_b(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, "lock_b1");
    // Requester 0 would win round-robin from ptr 2, but the lock holds requester 1
    step_b(4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, "lock_b2");
    reset_cycle(4'b0101, "rst_burst");
    step_b(4'b0101, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, "post_rst_burst");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
